// File: rtl/key_debounce.sv
// key_debounce: conditions active-low pushbutton pins into clean active-high
// levels plus one-cycle press/release events, one independent channel per key.
// Each channel: two-flop synchronizer -> STABLE/PENDING debounce FSM with a
// stability counter -> registered output stage (level, press, release).
// Optional auto-repeat of press pulses while a key stays held: compile with
// KEY_DEBOUNCE_REPEAT_EN defined. Without it no repeat logic exists and
// HOLD_CYCLES / REPEAT_CYCLES have no effect.
module key_debounce #(
  parameter int N               = 3,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic [N-1:0] iKEY,
  output logic [N-1:0] oKEY_LEVEL,
  output logic [N-1:0] oKEY_PRESS,
  output logic [N-1:0] oKEY_RELEASE
);

  // Counter is one bit wider than strictly needed; it is cleared at
  // DEBOUNCE_CYCLES-1, so it never wraps.
  localparam int            CW     = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_DEBOUNCE_REPEAT_EN
  // Repeat counter runs up to HOLD, then cycles HOLD..HOLD+REPEAT-1 so that a
  // pulse fires each time it sits at HOLD.
  localparam int            RW     = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] R_HOLD = RW'(HOLD_CYCLES);
  localparam logic [RW-1:0] R_WRAP = RW'(HOLD_CYCLES + REPEAT_CYCLES - 1);
`endif

  // Elaboration-time guard on parameter ranges.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 16777215 ||
      HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("key_debounce: parameter out of range");
  end

  typedef enum logic {STABLE, PENDING} state_t;

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    logic [1:0]    sync;        // sync[1] is the synchronized, active-high key
    logic          pressed;
    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          level, level_next;   // internal debounced level
    logic          level_out;           // registered copy driven to the pin
    logic          press_pulse;
    logic          rel_pulse;
    logic          rep;

    assign pressed = sync[1];

    // Two-flop synchronizer; key pins are active-low, so invert on entry.
    always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) sync <= 2'b00;
      else      sync <= {sync[0], ~iKEY[gi]};
    end

    // Debounce FSM state, stability counter and accepted level.
    always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
        state <= STABLE;
        cnt   <= '0;
        level <= 1'b0;
      end else begin
        state <= state_next;
        cnt   <= cnt_next;
        level <= level_next;
      end
    end

    // Next-state: any cycle agreeing with the level is a glitch and restarts
    // the count; DEBOUNCE_CYCLES consecutive disagreeing cycles flip the level.
    always_comb begin
      state_next = state;
      cnt_next   = cnt;
      level_next = level;
      case (state)
        STABLE: begin
          cnt_next = '0;
          if (pressed != level) begin
            state_next = PENDING;
            cnt_next   = cnt + 1'b1;
          end
        end
        PENDING: begin
          if (pressed == level) begin
            state_next = STABLE;
            cnt_next   = '0;
          end else if (cnt == C_LAST) begin
            state_next = STABLE;
            cnt_next   = '0;
            level_next = ~level;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: begin
          state_next = STABLE;
          cnt_next   = '0;
        end
      endcase
    end

`ifdef KEY_DEBOUNCE_REPEAT_EN
    logic [RW-1:0] rcnt;

    assign rep = level && (rcnt == R_HOLD);

    // Hold/repeat timer: runs only while the key is accepted as pressed.
    always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST)                rcnt <= '0;
      else if (!level)         rcnt <= '0;
      else if (rcnt == R_WRAP) rcnt <= R_HOLD;
      else                     rcnt <= rcnt + 1'b1;
    end
`else
    assign rep = 1'b0;
`endif

    // Output stage: level and edge pulses change together one cycle after
    // acceptance; press and release are mutually exclusive by construction.
    always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
        level_out   <= 1'b0;
        press_pulse <= 1'b0;
        rel_pulse   <= 1'b0;
      end else begin
        level_out   <= level;
        press_pulse <= (level & ~level_out) | rep;
        rel_pulse   <= ~level & level_out;
      end
    end

    assign oKEY_LEVEL[gi]   = level_out;
    assign oKEY_PRESS[gi]   = press_pulse;
    assign oKEY_RELEASE[gi] = rel_pulse;
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed + randomized stimulus for key_debounce. A
// reference model (sliding window over the synchronized key history) pushes
// the expected outputs of every cycle into a scoreboard queue; a separate
// monitor pops and compares one entry per cycle.
module tb_key_debounce;
  localparam int N    = 3;
  localparam int D    = 8;
  localparam int HOLD = 20;
  localparam int REP  = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] key = '1;
  logic [N-1:0] level, press, rel;

  int n_checks = 0;
  int n_fail   = 0;
  int pc       = 0;
  int cyc      = 0;

  typedef struct {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
  } exp_t;
  exp_t sb[$];

  key_debounce #(
    .N(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .iCLK(clk), .iRST(rst), .iKEY(key),
    .oKEY_LEVEL(level), .oKEY_PRESS(press), .oKEY_RELEASE(rel)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Runs n cycles from a negedge, counting press pulses on channel ch.
  task automatic count_press(input int ch, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pc += int'(press[ch]);
      @(negedge clk);
    end
  endtask

  // Reference model: a level flips once the last D synchronized samples seen
  // by the debouncer (inputs sampled 2..D+1 edges ago) all disagree with it.
  initial begin : model
    bit           hist [N][D+2];
    bit [N-1:0]   lvl_m;
    bit [N-1:0]   up;
    bit [N-1:0]   dn;
    bit           all_diff;
    exp_t         e;
`ifdef KEY_DEBOUNCE_REPEAT_EN
    int           press_at [N];
`endif
    lvl_m = '0;
    up    = '0;
    dn    = '0;
    foreach (hist[c, j]) hist[c][j] = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        e.level = '0;
        e.press = '0;
        e.rel   = '0;
        lvl_m   = '0;
        up      = '0;
        dn      = '0;
        foreach (hist[c, j]) hist[c][j] = 1'b0;
      end else begin
        e.level = lvl_m;
        e.press = up;
        e.rel   = dn;
`ifdef KEY_DEBOUNCE_REPEAT_EN
        for (int c = 0; c < N; c++)
          if (lvl_m[c] && (cyc - press_at[c]) >= HOLD && ((cyc - press_at[c] - HOLD) % REP) == 0)
            e.press[c] = 1'b1;
`endif
        up = '0;
        dn = '0;
        for (int c = 0; c < N; c++) begin
          for (int j = D + 1; j > 0; j--) hist[c][j] = hist[c][j-1];
          hist[c][0] = ~key[c];
          all_diff = 1'b1;
          for (int j = 2; j <= D + 1; j++)
            if (hist[c][j] == lvl_m[c]) all_diff = 1'b0;
          if (all_diff) begin
            lvl_m[c] = ~lvl_m[c];
            if (lvl_m[c]) begin
              up[c] = 1'b1;
`ifdef KEY_DEBOUNCE_REPEAT_EN
              press_at[c] = cyc + 1;
`endif
            end else begin
              dn[c] = 1'b1;
            end
          end
        end
      end
      sb.push_back(e);
    end
  end

  // Monitor: one scoreboard entry per cycle, compared just after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_empty: no expected entry at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        check_vec("sb_level", level, e.level);
        check_vec("sb_press", press, e.press);
        check_vec("sb_release", rel, e.rel);
      end
    end
  end

  initial begin : stim
    int left [N];

    // Reset with keys released, then idle.
    hold(4);
    check_vec("reset_level", level, '0);
    check_vec("reset_press", press, '0);
    check_vec("reset_release", rel, '0);
    rst = 1'b0;
    hold(50);
    check_vec("idle_level", level, '0);

    // Clean press on key 0: level/press at edge t+10.
    key[0] = 1'b0;
    repeat (10) @(posedge clk); #1;
    check_vec("press0_t9_level", level, 3'b000);
    @(posedge clk); #1;
    check_vec("press0_t10_level", level, 3'b001);
    check_vec("press0_t10_press", press, 3'b001);
    @(posedge clk); #1;
    check_vec("press0_t11_press", press, 3'b000);
    @(negedge clk);
    hold(5);
    key[0] = 1'b1;
    repeat (10) @(posedge clk); #1;
    check_vec("rel0_t9_release", rel, 3'b000);
    @(posedge clk); #1;
    check_vec("rel0_t10_release", rel, 3'b001);
    check_vec("rel0_t10_level", level, 3'b000);
    @(posedge clk); #1;
    check_vec("rel0_t11_release", rel, 3'b000);
    @(negedge clk);
    hold(3);

    // Bouncing key 1: low 3, high 2, low 5, then steady low.
    pc = 0;
    key[1] = 1'b0; count_press(1, 3);
    key[1] = 1'b1; count_press(1, 2);
    key[1] = 1'b0; count_press(1, 5);
    count_press(1, 25);
    check_int("bounce1_press_count", pc, 1);
    check_vec("bounce1_level", level, 3'b010);

    // Reset while key 0 is pending (counter at 5), key 1 still held.
    key[0] = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_vec("midreset_level", level, '0);
    check_vec("midreset_press", press, '0);
    hold(3);
    rst = 1'b0;
    repeat (10) @(posedge clk); #1;
    check_vec("postreset_t9_level", level, 3'b000);
    @(posedge clk); #1;
    check_vec("postreset_t10_press", press, 3'b011);
    check_vec("postreset_t10_level", level, 3'b011);
    @(negedge clk);
    key = '1;
    hold(20);

    // All keys pressed in the same cycle.
    key = '0;
    repeat (11) @(posedge clk); #1;
    check_vec("all_press", press, 3'b111);
    check_vec("all_level", level, 3'b111);
    @(negedge clk);
    hold(10);
    key = '1;
    hold(15);

    // Long hold on key 0: auto-repeat pulses only when enabled.
    pc = 0;
    key[0] = 1'b0;
    count_press(0, 72);
    key[0] = 1'b1;
    count_press(0, 24);
`ifdef KEY_DEBOUNCE_REPEAT_EN
    check_int("hold0_press_count", pc, 12);
`else
    check_int("hold0_press_count", pc, 1);
`endif
    check_vec("hold0_level_after", level, 3'b000);

    // Randomized key activity with occasional reset pulses.
    foreach (left[c]) left[c] = $urandom_range(1, 20);
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int c = 0; c < N; c++) begin
        left[c]--;
        if (left[c] == 0) begin
          key[c]  = ~key[c];
          left[c] = $urandom_range(1, 20);
        end
      end
      @(negedge clk);
    end
    rst = 1'b0;
    key = '1;
    hold(30);
    check_vec("final_level", level, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
